// File: rtl/ext.sv
// Immediate extender: sign/zero-extend or upper-load form of a 16-bit field,
// registered with one cycle of latency and a qualifying valid flag.
module ext (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] imm,
    input  logic        ext_op,
    input  logic        ext_result,
    input  logic        in_valid,
    output logic [31:0] out,
    output logic        out_valid
);

    logic [31:0] next_out;

    // Upper-load form wins over the extension kind.
    always_comb begin
        next_out = {16'h0000, imm};
        if (ext_result) begin
            next_out = {imm, 16'h0000};
        end else if (ext_op) begin
            next_out = {{16{imm[15]}}, imm};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out       <= 32'h0000_0000;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= next_out;
            end
        end
    end

endmodule

// File: tb/tb_ext.sv
// Bench for ext: directed corner cases plus randomized traffic against
// an arithmetic reference model with one-cycle latency.
module tb_ext;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] imm;
    logic        ext_op;
    logic        ext_result;
    logic        in_valid;
    logic [31:0] out;
    logic        out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_out   = 32'h0;
    logic        m_valid = 1'b0;

    ext dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imm        (imm),
        .ext_op     (ext_op),
        .ext_result (ext_result),
        .in_valid   (in_valid),
        .out        (out),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] i,
                                          input logic op,
                                          input logic r);
        int unsigned u;
        u = i;
        if (r) return u * 65536;
        if (op && u >= 32768) return u + 32'hFFFF_0000;
        return u;
    endfunction

    task automatic step(input logic rn, input logic v,
                        input logic [15:0] i, input logic op,
                        input logic r, input string tag);
        rst_n      = rn;
        in_valid   = v;
        imm        = i;
        ext_op     = op;
        ext_result = r;
        @(posedge clk);
        if (!rn) begin
            m_out   = 32'h0;
            m_valid = 1'b0;
        end else begin
            m_valid = v;
            if (v) m_out = model(i, op, r);
        end
        #1;
        check({tag, "_out"}, out, m_out);
        check({tag, "_vld"}, {31'b0, out_valid}, {31'b0, m_valid});
    endtask

    initial begin
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, "rst0");
        step(1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, "rst1");
        check("rst_lit", out, 32'h0000_0000);

        step(1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, "r021");
        check("r021_lit", out, 32'h0000_0001);

        step(1'b1, 1'b1, 16'h8000, 1'b1, 1'b0, "r022a");
        check("r022a_lit", out, 32'hFFFF_8000);
        step(1'b1, 1'b1, 16'h8000, 1'b0, 1'b0, "r022b");
        check("r022b_lit", out, 32'h0000_8000);

        step(1'b1, 1'b1, 16'h8001, 1'b1, 1'b1, "r023a");
        check("r023a_lit", out, 32'h8001_0000);
        step(1'b1, 1'b1, 16'h8001, 1'b0, 1'b1, "r023b");
        check("r023b_lit", out, 32'h8001_0000);

        step(1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b0, "r024a");
        check("r024a_lit", out, 32'h0000_7FFF);
        step(1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b1, "r024b");
        check("r024b_lit", out, 32'h0000_7FFF);

        step(1'b1, 1'b1, 16'hABCD, 1'b0, 1'b0, "pre025");
        step(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, "r025");
        check("r025_lit", out, 32'h0000_0000);

        step(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, "warm");
        check("warm_lit", out, 32'hFFFF_FFFF);

        // A reset pulse between edges must not disturb the outputs.
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        check("glitch_out", out, 32'hFFFF_FFFF);
        check("glitch_vld", {31'b0, out_valid}, 32'h1);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, "hold");

        for (int k = 0; k < 1000; k++) begin
            step(1'b1, ($urandom_range(0, 3) != 0),
                 16'($urandom), 1'($urandom), 1'($urandom), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
